calc_core: RTL
==============

# calc_core

Operation engine on the consumer side of the debounced push-button interface. Accepts the single-cycle, one-hot operation pulses from the button debouncer (add, subtract, multiply, divide) together with two switch-supplied operands. Executes the operation, iteratively for multiply and divide, and presents a registered result with a one-cycle done strobe to the display path.

## Interface

Parameters:
- `WIDTH`, default 8: operand width. The result is `2*WIDTH` bits.

Ports:
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `op_i`  input  4: one-hot operation pulse from the debouncer, high for exactly one cycle.
  - bit3 = add
  - bit2 = sub
  - bit1 = mul
  - bit0 = div
- `a_i`  input  WIDTH: operand A (unsigned), sampled on the accepted pulse.
- `b_i`  input  WIDTH: operand B (unsigned), sampled on the accepted pulse.
- `busy_o`  output  1: high while an operation is in progress or completing.
- `done_o`  output  1: one-cycle strobe; `result_o` and `err_o` are valid from this cycle on.
- `result_o`  output  2*WIDTH: last result; held until the next `done_o`.
- `err_o`  output  1: divide-by-zero flag for the last result; held until the next `done_o`.

## Operation

States:
- IDLE: waiting for an operation pulse.
- CALC: iterating a multiply or divide.
- DONE: presenting the result for one cycle.

IDLE behaviour:
- A nonzero `op_i` is accepted. `a_i`, `b_i` and the op are latched on the same edge.
- If more than one bit is set, priority is bit3 > bit2 > bit1 > bit0. The upstream debouncer never produces this; the priority is defined for robustness only.
- Add: the result register is loaded with zero-extended A + zero-extended B, then the FSM enters DONE.
- Sub: the result register is loaded with ({WIDTH'b0,A} − {WIDTH'b0,B}) mod 2^(2*WIDTH), then the FSM enters DONE. A negative difference wraps, e.g. 3−5 = 0xFFFE.
- Mul: the FSM enters CALC. Shift-add, one multiplier bit per cycle, LSB first, exactly WIDTH iterations.
- Div:
  - If B == 0: enter DONE directly with `result_o` = all ones and `err_o` = 1.
  - Otherwise: enter CALC. Restoring division, one quotient bit per cycle, MSB first, exactly WIDTH iterations.
  - Result packing: `result_o` = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.

CALC behaviour:
- A `$clog2(WIDTH)+1`-bit iteration counter starts at 0.
- After the iteration with counter == WIDTH−1, the final value is written to `result_o` and the FSM enters DONE.

DONE behaviour:
- `done_o` = 1 for this single cycle, then the FSM returns to IDLE.
- `err_o` is updated on the same edge as `result_o`: 1 only for divide-by-zero, 0 for all other ops.

Pulse and operand handling:
- Any `op_i` pulse arriving while `busy_o` = 1 (CALC or DONE) is dropped. It is not queued.
- `a_i` and `b_i` changing after acceptance have no effect on the operation in progress.

Reset:
- Reset values: IDLE, `busy_o` = 0, `done_o` = 0, `result_o` = 0, `err_o` = 0, counter = 0.
- Reset asserted mid-CALC aborts the operation immediately. No `done_o` is produced.

## Timing

- The pulse is sampled at edge k (k = the first rising edge at which `op_i` is high).
- Add, sub, and divide-by-zero: `busy_o` and `done_o` are high in cycle k+1. `busy_o` is low from cycle k+2.
- Mul and nonzero div: `busy_o` is high for cycles k+1 … k+WIDTH+1. `done_o` is high in cycle k+WIDTH+1 (cycle k+9 for WIDTH = 8). `busy_o` is low from cycle k+WIDTH+2.
- The earliest next acceptance is the edge ending the first IDLE cycle. Back-to-back adds can therefore complete every 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Add: reset release, A=3, B=5, pulse `op_i`=4'b1000 → `done_o` one cycle later, `result_o`=0x0008, `err_o`=0, `busy_o` high for exactly 1 cycle.
- Sub wrap: A=3, B=5, pulse 4'b0100 → `result_o`=0xFFFE. Then A=200, B=55 → `result_o`=0x0091.
- Mul: A=200, B=150, pulse 4'b0010 → `busy_o` high 9 cycles, `done_o` in the 9th, `result_o`=0x7530. Change `a_i` and `b_i` during CALC → result unchanged. Repeat with 255×255 → 0xFE01.
- Div: A=100, B=7, pulse 4'b0001 → after 9 cycles `result_o`=0x020E, `err_o`=0.
  - Then B=0 → `done_o` one cycle after the pulse, `result_o`=0xFFFF, `err_o`=1.
  - Then a following add → `err_o` returns to 0.
- Busy drop: pulse mul, then pulse add at the 3rd cycle of CALC and again in the DONE cycle → only the mul completes. Exactly one `done_o` is produced and no second result appears.
- Reset mid-op: start div 100/7, assert `rst_n`=0 asynchronously at the 4th CALC cycle → all outputs 0 immediately. After release, no `done_o` appears, and a fresh add of 1+1 → 0x0002.

Source files
------------

// File: rtl/calc_core.sv
// Operation engine behind the push-button debouncer: single-cycle add/sub,
// iterative shift-add multiply and restoring divide, registered result with done strobe.
module calc_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 err_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t           state, state_next;
  op_t              op_sel, op_q;
  logic             op_valid;
  logic [CW-1:0]    cnt;
  logic             last_iter;

  // multiply working registers
  logic [RW-1:0]    acc, mcand, acc_step;
  logic [WIDTH-1:0] mplier;

  // divide working registers
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH:0]   trial, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step;

  // Multi-hot pulses resolve add > sub > mul > div.
  always_comb begin
    op_valid = |op_i;
    op_sel   = OP_DIV;
    if (op_i[3])      op_sel = OP_ADD;
    else if (op_i[2]) op_sel = OP_SUB;
    else if (op_i[1]) op_sel = OP_MUL;
  end

  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - {1'b0, divisor};
    fits     = (trial >= {1'b0, divisor});
    rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          unique case (op_sel)
            OP_ADD, OP_SUB: state_next = DONE;
            OP_MUL:         state_next = CALC;
            OP_DIV:         state_next = (b_i == '0) ? DONE : CALC;
            default:        state_next = IDLE;
          endcase
        end
      end
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_o <= '0;
      err_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            op_q <= op_sel;
            cnt  <= '0;
            unique case (op_sel)
              OP_ADD: begin
                result_o <= {{WIDTH{1'b0}}, a_i} + {{WIDTH{1'b0}}, b_i};
                err_o    <= 1'b0;
              end
              OP_SUB: begin
                result_o <= {{WIDTH{1'b0}}, a_i} - {{WIDTH{1'b0}}, b_i};
                err_o    <= 1'b0;
              end
              OP_MUL: begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_i};
                mplier <= b_i;
              end
              OP_DIV: begin
                if (b_i == '0) begin
                  result_o <= '1;
                  err_o    <= 1'b1;
                end else begin
                  rem     <= '0;
                  quo     <= a_i;
                  divisor <= b_i;
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_q == OP_MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last_iter) begin
              result_o <= acc_step;
              err_o    <= 1'b0;
            end
          end else begin
            rem <= rem_step;
            quo <= quo_step;
            if (last_iter) begin
              result_o <= {rem_step, quo_step};
              err_o    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
